// File: rtl/l2_wb_pkg.sv
// Shared types and widths for the L2 writeback buffer.
package l2_wb_pkg;
  localparam int S_OFFSET = 5;
  localparam int LINE_W   = 256;
  localparam int TAG_W    = 32 - S_OFFSET;

  typedef enum logic [1:0] {IDLE, MEM_READ, MEM_WRITE} wb_state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/l2_wb_match.sv
// Associative compare of one line tag against every buffered entry.
// mask removes entries from consideration (the head while it is draining).
module l2_wb_match
  import l2_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [TAG_W-1:0]            tag,
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [DEPTH-1:0]            mask,
  output logic                        hit,
  output logic [DEPTH-1:0]            onehot
);
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign onehot[i] = valid[i] && !mask[i] && (tags[i] == tag);
  end

  // Coalescing keeps tags unique, so onehot has at most one bit set.
  assign hit = |onehot;
endmodule

// File: rtl/l2_writeback_buffer.sv
// Victim-line FIFO between L2 and pmem. Coalesces repeat victims, forwards
// buffered lines to L2 read misses and drains to pmem when otherwise idle.
module l2_writeback_buffer
  import l2_wb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int s_offset = S_OFFSET,
  parameter int s_line   = LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_write,
  input  logic [31:0]       wb_address,
  input  logic [s_line-1:0] wb_wdata,
  output logic              wb_resp,
  input  logic              l2_read,
  input  logic [31:0]       l2_address,
  output logic [s_line-1:0] l2_rdata,
  output logic              l2_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              wb_full,
  output logic              wb_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  wb_state_t state, state_nxt;
  wb_entry_t ents [DEPTH];

  logic [PW-1:0]            head, tail;
  logic [PW:0]              count, count_nxt;
  logic [DEPTH-1:0]         ent_vld, head_oh, drain_mask;
  logic [DEPTH-1:0][TAG_W-1:0] ent_tag;
  logic [DEPTH-1:0]         push_oh, rd_oh;
  logic [TAG_W-1:0]         push_tag, rd_tag;
  logic                     push_hit, rd_hit, head_busy;
  logic                     push_req, push_cl, push_al, pop, rd_req, rd_fwd, rd_done;
  logic [s_line-1:0]        fwd_data;
  logic                     unused_addr_bits;

  assign push_tag = wb_address[31:s_offset];
  assign rd_tag   = l2_address[31:s_offset];
  assign unused_addr_bits = ^{wb_address[s_offset-1:0], l2_address[s_offset-1:0]};

  // Flatten entry valid/tag fields for the match units.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i] = ents[i].valid;
      ent_tag[i] = ents[i].tag;
    end
  end

  assign head_oh    = DEPTH'(1) << head;
  assign drain_mask = (state == MEM_WRITE) ? head_oh : '0;
  // A push matching the head mid-drain must wait for the pop, then allocate.
  assign head_busy  = (state == MEM_WRITE) && ent_vld[head] && (ent_tag[head] == push_tag);

  l2_wb_match #(.DEPTH(DEPTH)) u_push_match (
    .tag(push_tag), .valid(ent_vld), .tags(ent_tag), .mask(drain_mask),
    .hit(push_hit), .onehot(push_oh)
  );

  l2_wb_match #(.DEPTH(DEPTH)) u_rd_match (
    .tag(rd_tag), .valid(ent_vld), .tags(ent_tag), .mask('0),
    .hit(rd_hit), .onehot(rd_oh)
  );

  assign push_req  = wb_write && !wb_resp;
  assign push_cl   = push_req && push_hit;
  assign push_al   = push_req && !push_hit && !head_busy && (count != FULL_CNT);
  assign pop       = (state == MEM_WRITE) && pmem_resp;
  assign rd_req    = (state == IDLE) && l2_read && !l2_resp;
  assign rd_fwd    = rd_req && rd_hit;
  assign rd_done   = (state == MEM_READ) && pmem_resp;
  assign count_nxt = count + (PW+1)'(push_al) - (PW+1)'(pop);

  // Forward-data mux: OR of the (at most one) matching entry.
  always_comb begin
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_oh[i]) fwd_data = fwd_data | ents[i].data;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: reads beat draining; one pmem transaction at a time.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_req) begin
          if (!rd_hit) state_nxt = MEM_READ;
        end else if (count != '0) begin
          state_nxt = MEM_WRITE;
        end
      end
      MEM_READ:  if (pmem_resp) state_nxt = IDLE;
      MEM_WRITE: if (pmem_resp) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // pmem request strobes decode straight from state so reset drops them at once.
  always_comb begin
    pmem_read  = (state == MEM_READ);
    pmem_write = (state == MEM_WRITE);
  end

  // Pointers, count, flags, handshakes and the latched pmem/L2 datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      wb_resp      <= 1'b0;
      l2_resp      <= 1'b0;
      wb_full      <= 1'b0;
      wb_empty     <= 1'b1;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      l2_rdata     <= '0;
    end else begin
      wb_resp  <= push_cl || push_al;
      l2_resp  <= rd_fwd || rd_done;
      count    <= count_nxt;
      wb_full  <= (count_nxt == FULL_CNT);
      wb_empty <= (count_nxt == '0);
      if (push_al) tail <= tail + 1'b1;
      if (pop)     head <= head + 1'b1;
      if (rd_fwd)       l2_rdata <= fwd_data;
      else if (rd_done) l2_rdata <= pmem_rdata;
      if (state == IDLE && state_nxt == MEM_READ) begin
        pmem_address <= {rd_tag, {s_offset{1'b0}}};
      end else if (state == IDLE && state_nxt == MEM_WRITE) begin
        pmem_address <= {ents[head].tag, {s_offset{1'b0}}};
        // A coalesce into the head on this same edge must not be lost.
        pmem_wdata   <= (push_cl && push_oh[head]) ? wb_wdata : ents[head].data;
      end
    end
  end

  // Entry storage: coalesce/allocate writes, pop clears the head valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((push_cl && push_oh[i]) || (push_al && tail == PW'(i))) begin
          ents[i].valid <= 1'b1;
          ents[i].tag   <= push_tag;
          ents[i].data  <= wb_wdata;
        end else if (pop && head == PW'(i)) begin
          ents[i].valid <= 1'b0;
        end
      end
    end
  end
endmodule
